// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared types and constants for the gate-model test sequencer.
package gate_seq_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_e;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_INIT = 16'hFFFF;
  localparam int LFSR_TAP_HI = 17;
  localparam int LFSR_TAP_LO = 10;
  function automatic logic [15:0] misr_shift(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/gate_seq_misr.sv
// gate_seq_misr: 16-bit multiple-input signature register with init and enable.
module gate_seq_misr
  import gate_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [15:0] data_i,
  output logic [15:0] sig_o
);
  logic [15:0] sig_q, sig_d;
  always_comb sig_d = init_i ? MISR_INIT : en_i ? misr_shift(sig_q) ^ data_i : sig_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig_q <= MISR_INIT;
    else sig_q <= sig_d;
  assign sig_o = sig_q;
endmodule

// File: rtl/gate_model_sequencer.sv
// gate_model_sequencer: drives exhaustive or LFSR vectors into a gate model,
// captures each response after a settle time, streams it out and compacts it into a MISR.
module gate_model_sequencer
  import gate_seq_pkg::*;
#(
  parameter int IN_W   = 18,
  parameter int OUT_W  = 10,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [IN_W-1:0]  seed,
  input  logic [IN_W:0]    vec_count,
  input  logic             abort,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             cap_valid,
  output logic [OUT_W-1:0] cap_data,
  input  logic             cap_ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature
);
  state_e state_q, state_d;
  logic [IN_W-1:0] vec_q, vec_d, next_vec;
  logic [IN_W:0] rem_q, rem_d;
  logic [3:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] cap_q, cap_d;
  logic mode_q, mode_d, misr_init, misr_en;
  assign next_vec = mode_q ? {vec_q[IN_W-2:0], vec_q[LFSR_TAP_HI] ^ vec_q[LFSR_TAP_LO]}
                           : vec_q + 1'b1;
  // abort overrides every transition and freezes vector, capture and signature
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    cap_d = cap_q;
    mode_d = mode_q;
    misr_init = 1'b0;
    misr_en = 1'b0;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        misr_init = 1'b1;
        mode_d = mode;
        state_d = (vec_count == '0) ? DONE : DRIVE;
        if (vec_count != '0) begin
          rem_d = vec_count;
          vec_d = (mode && seed == '0) ? IN_W'(1) : seed;
          cnt_d = 4'(SETTLE);
        end
      end
      DRIVE: if (cnt_q == 4'd1) begin
        state_d = CAPTURE;
        cap_d = dut_out;
        misr_en = 1'b1;
      end else cnt_d = cnt_q - 4'd1;
      CAPTURE: if (cap_ready) begin
        rem_d = rem_q - 1'b1;
        state_d = (rem_q == (IN_W+1)'(1)) ? DONE : DRIVE;
        if (rem_q != (IN_W+1)'(1)) begin
          vec_d = next_vec;
          cnt_d = 4'(SETTLE);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      cap_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      cap_q <= cap_d;
      mode_q <= mode_d;
    end
  gate_seq_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_i (misr_init),
    .en_i   (misr_en),
    .data_i (16'(dut_out)),
    .sig_o  (signature)
  );
  assign dut_in = vec_q;
  assign cap_data = cap_q;
  assign cap_valid = state_q == CAPTURE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_gate_model_sequencer.sv
// tb_gate_model_sequencer: table-driven and randomized runs checked against a vector/signature model.
module tb_gate_model_sequencer;
  localparam int SETTLE = 2;
  logic clk = 1'b0, rst_n, start, mode, abort, cap_ready, tie;
  logic [17:0] seed, dut_in, model_vec;
  logic [18:0] vec_count;
  logic [9:0] dut_out, cap_data;
  logic cap_valid, busy, done;
  logic [15:0] signature;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [9:0] gm(input logic [17:0] x);
    return {x[9:4] ^ x[15:10], x[0] ^ x[17], |x[17:14], &x[3:0], ^x};
  endfunction
  function automatic int misr_step(input int s, input int d);
    return ((s * 2) % 65536) ^ (s >= 32768 ? 'h1021 : 0) ^ d;
  endfunction
  function automatic int next_v(input bit m, input int x);
    return m ? ((x * 2) % 262144) + (((x >> 17) ^ (x >> 10)) & 1) : (x + 1) % 262144;
  endfunction

  assign dut_out = tie ? 10'd0 : gm(dut_in);

  gate_model_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
    .vec_count(vec_count), .abort(abort), .dut_in(dut_in), .dut_out(dut_out),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready),
    .busy(busy), .done(done), .signature(signature)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input bit m, input logic [17:0] s, input logic [18:0] n, input bit t,
                     input bit rnd, output logic [17:0] last, output logic [15:0] sig);
    logic [17:0] v[$];
    int x, es, idx, cyc;
    bit fin;
    x = (m && s == 0) ? 1 : int'(s);
    es = 'hFFFF;
    for (int i = 0; i < int'(n); i++) begin
      v.push_back(18'(x));
      es = misr_step(es, t ? 0 : int'(gm(18'(x))));
      x = next_v(m, x);
    end
    idx = 0;
    fin = 0;
    tie = t; mode = m; seed = s; vec_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (cyc = 1; cyc <= 300; cyc++) begin
      cap_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (busy && !done && idx < int'(n)) chk("dut_in_vec", dut_in, v[idx]);
      if (cap_valid) begin
        chk("valid_in_range", idx < int'(n), 1);
        if (idx < int'(n)) chk("cap_data", cap_data, t ? 10'd0 : gm(v[idx]));
        if (cap_ready) idx++;
      end
      if (done) begin
        fin = 1;
        if (!rnd) chk("done_cycle", cyc, int'(n) * (SETTLE + 1) + 1);
        break;
      end
      @(negedge clk);
    end
    if (!fin) begin
      errors++;
      $display("FAIL run_timeout: got no done expected done within 300 cycles");
    end
    chk("capture_count", idx, n);
    chk("signature_model", signature, es[15:0]);
    if (n != 0) model_vec = v[$];
    chk("dut_in_final", dut_in, model_vec);
    last = dut_in;
    sig = signature;
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("busy_released", busy, 0);
  endtask

  typedef struct {
    bit m; logic [17:0] s; logic [18:0] n; bit t;
    logic [17:0] exp_last; logic [15:0] exp_sig; bit sc;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic [17:0] last;
    logic [15:0] sig;
    int w, es;
    bit saw_done;
    tbl[0] = '{0, 18'h00000, 19'd4, 0, 18'h00003, 16'h0000, 0};
    tbl[1] = '{1, 18'h00000, 19'd3, 0, 18'h00004, 16'h0000, 0};
    tbl[2] = '{1, 18'h00400, 19'd2, 0, 18'h00801, 16'h0000, 0};
    tbl[3] = '{0, 18'h00005, 19'd1, 1, 18'h00005, 16'hEFDF, 1};
    tbl[4] = '{0, 18'h00000, 19'd2, 1, 18'h00001, 16'hCF9F, 1};
    tbl[5] = '{0, 18'h3FFFF, 19'd2, 0, 18'h00000, 16'h0000, 0};
    tbl[6] = '{0, 18'h00007, 19'd0, 0, 18'h00000, 16'hFFFF, 1};
    rst_n = 1'b0; start = 0; mode = 0; abort = 0; cap_ready = 1; tie = 0;
    seed = '0; vec_count = '0; model_vec = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", cap_valid, 0);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_cap_data", cap_data, 0);
    chk("rst_signature", signature, 16'hFFFF);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      run(tbl[i].m, tbl[i].s, tbl[i].n, tbl[i].t, 0, last, sig);
      chk($sformatf("tbl%0d_last", i), last, tbl[i].exp_last);
      if (tbl[i].sc) chk($sformatf("tbl%0d_sig", i), sig, tbl[i].exp_sig);
    end
    for (int r = 0; r < 8; r++)
      run(1'($urandom_range(0, 1)), 18'($urandom), 19'($urandom_range(1, 6)), 0, 1, last, sig);
    // backpressure: hold ready low through five CAPTURE cycles
    tie = 0; mode = 0; seed = 18'h00010; vec_count = 19'd2; cap_ready = 0; start = 1;
    @(negedge clk);
    start = 0;
    w = 0;
    while (!cap_valid && w < 20) begin @(negedge clk); w++; end
    chk("bp_valid_seen", cap_valid, 1);
    repeat (5) begin
      chk("bp_valid_hold", cap_valid, 1);
      chk("bp_data_hold", cap_data, gm(18'h00010));
      chk("bp_dut_in_hold", dut_in, 18'h00010);
      @(negedge clk);
    end
    cap_ready = 1;
    @(negedge clk);
    chk("bp_resume_valid", cap_valid, 0);
    chk("bp_resume_vec", dut_in, 18'h00011);
    w = 0;
    while (!done && w < 20) begin @(negedge clk); w++; end
    chk("bp_done", done, 1);
    es = misr_step(misr_step('hFFFF, int'(gm(18'h10))), int'(gm(18'h11)));
    chk("bp_sig", signature, es[15:0]);
    model_vec = 18'h00011;
    @(negedge clk);
    // start and abort together in IDLE: abort wins
    seed = 18'h00005; vec_count = 19'd1; start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("abort_start_idle", busy, 0);
    chk("abort_start_vec", dut_in, model_vec);
    // abort during DRIVE of the third vector
    seed = 18'h00000; vec_count = 19'd5; cap_ready = 1; start = 1;
    @(negedge clk);
    start = 0;
    w = 0;
    while (!(busy && !cap_valid && dut_in == 18'd2) && w < 30) begin @(negedge clk); w++; end
    chk("abort_reach_drive", dut_in, 2);
    abort = 1;
    @(negedge clk);
    abort = 0;
    es = misr_step(misr_step('hFFFF, int'(gm(18'd0))), int'(gm(18'd1)));
    chk("abort_busy", busy, 0);
    chk("abort_valid", cap_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_vec_held", dut_in, 2);
    chk("abort_sig_held", signature, es[15:0]);
    saw_done = 0;
    repeat (4) begin @(negedge clk); saw_done |= done; end
    chk("abort_no_done", saw_done, 0);
    // asynchronous reset mid-CAPTURE
    seed = 18'h00009; vec_count = 19'd3; cap_ready = 0; start = 1;
    @(negedge clk);
    start = 0;
    w = 0;
    while (!cap_valid && w < 20) begin @(negedge clk); w++; end
    chk("rst_mid_valid_seen", cap_valid, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", cap_valid, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_dut_in", dut_in, 0);
    chk("rst_mid_cap_data", cap_data, 0);
    chk("rst_mid_sig", signature, 16'hFFFF);
    @(negedge clk);
    rst_n = 1; cap_ready = 1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
